// File: rtl/i2c_slave_wb_pkg.sv
// i2c_slave_wb_pkg: register map, STAT bit positions and FSM states
package i2c_slave_wb_pkg;
    localparam logic [1:0] REG_SADR = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_IEN  = 2'd3;
    localparam int ST_RXV   = 7;
    localparam int ST_TXE   = 6;
    localparam int ST_BUSY  = 5;
    localparam int ST_DIR   = 4;
    localparam int ST_MNACK = 3;
    localparam int ST_STOP  = 2;
    localparam int ST_OVR   = 1;
    localparam logic [7:0] STAT_RST = 8'h40;
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
    } state_e;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-FF synchronizers plus registered SCL edge and START/STOP pulses
module i2c_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_o
);
    logic [2:0] scl_sh_q, scl_sh_d, sda_sh_q, sda_sh_d;
    logic [4:0] ev_q, ev_d;
    always_comb begin
        scl_sh_d = {scl_sh_q[1:0], scl_i};
        sda_sh_d = {sda_sh_q[1:0], sda_i};
        ev_d = {scl_sh_q[1] & ~scl_sh_q[2],
                ~scl_sh_q[1] & scl_sh_q[2],
                scl_sh_q[1] & scl_sh_q[2] & ~sda_sh_q[1] & sda_sh_q[2],
                scl_sh_q[1] & scl_sh_q[2] & sda_sh_q[1] & ~sda_sh_q[2],
                sda_sh_q[1]};
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_sh_q <= 3'b111;
            sda_sh_q <= 3'b111;
            ev_q     <= 5'b00001;
        end else begin
            scl_sh_q <= scl_sh_d;
            sda_sh_q <= sda_sh_d;
            ev_q     <= ev_d;
        end
    end
    // sda_o is the line level aligned with the edge pulses
    assign {scl_rise_o, scl_fall_o, start_o, stop_o, sda_o} = ev_q;
endmodule

// File: rtl/i2c_slave_wb.sv
// i2c_slave_wb: I2C slave endpoint with a Wishbone register port
// RX bytes land in DATA for the host; host-written TXD is shifted out on master reads.
module i2c_slave_wb
    import i2c_slave_wb_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cyc_i,
    input  logic                     stb_i,
    output logic                     ack_o,
    input  logic [WB_ADDR_WIDTH-1:0] adr_i,
    input  logic                     we_i,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    output logic                     irq_o,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     scl_o,
    output logic                     sda_o
);
    localparam logic [3:0] LAST_BIT = 4'(I2C_DATA_WIDTH - 1);
    localparam logic [3:0] ACK_BIT  = 4'(I2C_DATA_WIDTH);
    localparam logic [3:0] ACK_DONE = 4'(I2C_DATA_WIDTH + 1);

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [I2C_DATA_WIDTH-1:0] shreg_q, shreg_d, in_byte;
    logic [WB_DATA_WIDTH-1:0] sadr_q, sadr_d, ien_q, ien_d, rxd_q, rxd_d, txd_q, txd_d;
    logic [WB_DATA_WIDTH-1:0] stat_q, stat_d, dat_q, dat_d, tx_byte;
    logic sda_q, sda_d, irq_q, irq_d, ack_q, ack_d;
    logic scl_rise, scl_fall, start, stop, sda_s;
    logic wb_go, wb_wr, wb_rd, rd_data;
    logic [1:0] reg_sel;

    i2c_line_sync u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop),
        .sda_o      (sda_s)
    );

    assign reg_sel = adr_i[1:0];
    assign wb_go   = cyc_i & stb_i & ~ack_q;
    assign wb_wr   = wb_go & we_i;
    assign wb_rd   = wb_go & ~we_i;
    assign rd_data = wb_rd && reg_sel == REG_DATA;
    assign in_byte = {shreg_q[I2C_DATA_WIDTH-2:0], sda_s};
    assign tx_byte = stat_q[ST_TXE] ? '1 : txd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        sda_d   = sda_q;
        sadr_d  = sadr_q;
        ien_d   = ien_q;
        rxd_d   = rxd_q;
        txd_d   = txd_q;
        stat_d  = stat_q;
        ack_d   = wb_go;
        dat_d   = '0;
        irq_d   = |(stat_q & ien_q);
        if (wb_rd)
            dat_d = reg_sel == REG_SADR ? sadr_q :
                    reg_sel == REG_DATA ? rxd_q  :
                    reg_sel == REG_STAT ? stat_q : ien_q;
        if (rd_data) begin
            stat_d[ST_RXV] = 1'b0;
            stat_d[ST_OVR] = 1'b0;
        end
        if (wb_wr && reg_sel == REG_SADR) sadr_d = dat_i;
        if (wb_wr && reg_sel == REG_IEN) ien_d = dat_i;
        if (wb_wr && reg_sel == REG_STAT) begin
            stat_d[ST_MNACK] = stat_q[ST_MNACK] & ~dat_i[ST_MNACK];
            stat_d[ST_STOP]  = stat_q[ST_STOP] & ~dat_i[ST_STOP];
        end
        if (start) begin
            state_d = S_ADDR;
            cnt_d   = '0;
            sda_d   = 1'b1;
        end else if (stop) begin
            state_d = S_IDLE;
            sda_d   = 1'b1;
            stat_d[ST_BUSY] = 1'b0;
            if (stat_q[ST_BUSY]) stat_d[ST_STOP] = 1'b1;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    shreg_d = in_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == LAST_BIT) begin
                        if (sadr_q[WB_DATA_WIDTH-1] &&
                            sadr_q[I2C_ADDR_WIDTH-1:0] == shreg_q[I2C_ADDR_WIDTH-1:0]) begin
                            state_d = S_ADDR_ACK;
                            stat_d[ST_BUSY] = 1'b1;
                            stat_d[ST_DIR]  = sda_s;
                        end else begin
                            state_d = S_WAIT_STOP;
                            stat_d[ST_BUSY] = 1'b0;
                        end
                    end
                end
                // ACK slot: pull low on the 8th fall, hand over on the 9th
                S_ADDR_ACK, S_WR_ACK: begin
                    if (scl_rise) cnt_d = cnt_q + 4'd1;
                    if (scl_fall && cnt_q == ACK_BIT) sda_d = 1'b0;
                    if (scl_fall && cnt_q == ACK_DONE) begin
                        cnt_d = '0;
                        if (state_q == S_WR_ACK || !stat_q[ST_DIR]) begin
                            state_d = S_WR_DATA;
                            sda_d   = 1'b1;
                        end else begin
                            state_d = S_RD_DATA;
                            shreg_d = tx_byte;
                            sda_d   = tx_byte[I2C_DATA_WIDTH-1];
                            stat_d[ST_TXE] = 1'b1;
                        end
                    end
                end
                S_WR_DATA: if (scl_rise) begin
                    shreg_d = in_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = S_WR_ACK;
                        rxd_d   = in_byte;
                        stat_d[ST_RXV] = 1'b1;
                        if (!rd_data) stat_d[ST_OVR] = stat_q[ST_OVR] | stat_q[ST_RXV];
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) cnt_d = cnt_q + 4'd1;
                    if (scl_fall && cnt_q == ACK_BIT) begin
                        state_d = S_RD_ACK;
                        sda_d   = 1'b1;
                    end else if (scl_fall) begin
                        shreg_d = shreg_q << 1;
                        sda_d   = shreg_q[I2C_DATA_WIDTH-2];
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_d = S_WAIT_STOP;
                        stat_d[ST_MNACK] = 1'b1;
                    end else if (scl_rise) begin
                        cnt_d = ACK_DONE;
                    end
                    if (scl_fall && cnt_q == ACK_DONE) begin
                        state_d = S_RD_DATA;
                        cnt_d   = '0;
                        shreg_d = tx_byte;
                        sda_d   = tx_byte[I2C_DATA_WIDTH-1];
                        stat_d[ST_TXE] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // a host DATA write after a same-cycle TXD load keeps the new byte pending
        if (wb_wr && reg_sel == REG_DATA) begin
            txd_d = dat_i;
            stat_d[ST_TXE] = 1'b0;
        end
        stat_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            sda_q   <= 1'b1;
            sadr_q  <= '0;
            ien_q   <= '0;
            rxd_q   <= '0;
            txd_q   <= '0;
            stat_q  <= WB_DATA_WIDTH'(STAT_RST);
            ack_q   <= 1'b0;
            dat_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            sda_q   <= sda_d;
            sadr_q  <= sadr_d;
            ien_q   <= ien_d;
            rxd_q   <= rxd_d;
            txd_q   <= txd_d;
            stat_q  <= stat_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            irq_q   <= irq_d;
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign irq_o = irq_q;
    assign sda_o = sda_q;
    assign scl_o = 1'b1;
endmodule

// File: tb/tb_i2c_slave_wb.sv
// tb_i2c_slave_wb: random I2C master + Wishbone host against a transaction-level register model
module tb_i2c_slave_wb;
    localparam time Q = 60;
    logic clk = 1'b0, rst_n = 1'b0;
    logic cyc = 1'b0, stb = 1'b0, we = 1'b0, ack, irq, scl_o, sda_o;
    logic [1:0] adr = '0;
    logic [7:0] dat_w = '0, dat_r;
    logic scl_m = 1'b1, sda_m = 1'b1, scl_line, sda_line;
    int n_cmp = 0, n_bad = 0, low_cnt = 0;
    bit m_rxv, m_txe, m_busy, m_dir, m_mnack, m_stop, m_ovr;
    logic [7:0] m_sadr, m_ien, m_rxd, m_txd;

    assign scl_line = scl_m & scl_o;
    assign sda_line = sda_m & sda_o;

    i2c_slave_wb dut (
        .clk_i (clk), .rst_i (rst_n), .cyc_i (cyc), .stb_i (stb), .ack_o (ack),
        .adr_i (adr), .we_i (we), .dat_i (dat_w), .dat_o (dat_r), .irq_o (irq),
        .scl_i (scl_line), .sda_i (sda_line), .scl_o (scl_o), .sda_o (sda_o)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (!sda_o) low_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_stat();
        return {m_rxv, m_txe, m_busy, m_dir, m_mnack, m_stop, m_ovr, 1'b0};
    endfunction

    task automatic m_reset();
        {m_rxv, m_busy, m_dir, m_mnack, m_stop, m_ovr} = '0;
        m_txe = 1'b1;
        m_sadr = '0; m_ien = '0; m_rxd = '0; m_txd = '0;
    endtask

    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [7:0] d, output logic [7:0] r);
        int waited = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!ack && waited < 8);
        r = dat_r;
        chk("wb_ack_lat", waited, 1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("wb_ack_pulse", ack, 0);
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] r;
        wb_xfer(1'b1, a, d, r);
        case (a)
            2'd0: m_sadr = d;
            2'd1: begin m_txd = d; m_txe = 1'b0; end
            2'd2: begin if (d[3]) m_mnack = 1'b0; if (d[2]) m_stop = 1'b0; end
            default: m_ien = d;
        endcase
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] r;
        wb_xfer(1'b0, a, 8'h00, r);
        chk(tag, r, exp);
        if (a == 2'd1) begin m_rxv = 1'b0; m_ovr = 1'b0; end
    endtask

    task automatic check_stat(input string tag);
        repeat (6) @(posedge clk);
        rd_chk(tag, 2'd2, m_stat());
        chk("irq", irq, |(m_stat() & m_ien));
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
    endtask
    task automatic i2c_stop();
        sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask
    task automatic put_bit(input logic b);
        sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    endtask
    task automatic get_bit(output logic b);
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_line; #Q; scl_m = 1'b0; #Q;
    endtask
    task automatic put_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        acked = ~b;
    endtask
    task automatic get_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin get_bit(b); d[i] = b; end
        put_bit(nack);
    endtask

    task automatic master_write(input logic [6:0] a, input int n, input logic [7:0] b0);
        logic acked, hit;
        logic [7:0] b;
        int low0 = low_cnt;
        hit = m_sadr[7] && a == m_sadr[6:0];
        i2c_start();
        put_byte({a, 1'b0}, acked);
        chk("wr_addr_ack", acked, hit);
        if (hit) begin
            m_busy = 1'b1; m_dir = 1'b0;
            for (int i = 0; i < n; i++) begin
                b = (i == 0) ? b0 : 8'($urandom);
                put_byte(b, acked);
                chk("wr_data_ack", acked, 1);
                m_ovr = m_ovr | m_rxv; m_rxv = 1'b1; m_rxd = b;
            end
        end else m_busy = 1'b0;
        i2c_stop();
        if (!hit) chk("nack_sda_quiet", low_cnt - low0, 0);
        if (m_busy) m_stop = 1'b1;
        m_busy = 1'b0;
        check_stat("wr_stat");
    endtask

    task automatic master_read(input logic [6:0] a, input int n);
        logic acked, hit;
        logic [7:0] d, exp;
        hit = m_sadr[7] && a == m_sadr[6:0];
        i2c_start();
        put_byte({a, 1'b1}, acked);
        chk("rd_addr_ack", acked, hit);
        if (hit) begin
            m_busy = 1'b1; m_dir = 1'b1;
            for (int i = 0; i < n; i++) begin
                exp = m_txe ? 8'hFF : m_txd;
                m_txe = 1'b1;
                get_byte(d, i == n - 1);
                chk("rd_data", d, exp);
            end
            m_mnack = 1'b1;
        end else m_busy = 1'b0;
        i2c_stop();
        if (m_busy) m_stop = 1'b1;
        m_busy = 1'b0;
        check_stat("rd_stat");
    endtask

    initial begin
        logic acked, b;
        m_reset();
        repeat (3) @(posedge clk); #1;
        chk("rst_ack", ack, 0);
        chk("rst_dat", dat_r, 0);
        chk("rst_irq", irq, 0);
        chk("rst_scl", scl_o, 1);
        chk("rst_sda", sda_o, 1);
        @(negedge clk); rst_n = 1'b1;
        rd_chk("rst_stat", 2'd2, 8'h40);
        rd_chk("rst_sadr", 2'd0, 8'h00);
        rd_chk("rst_ien", 2'd3, 8'h00);
        rd_chk("rst_data", 2'd1, 8'h00);
        wb_wr(2'd0, 8'hA2);
        rd_chk("sadr_rb", 2'd0, 8'hA2);
        // directed write, read, mismatch and overrun cases
        master_write(7'h22, 1, 8'h55);
        rd_chk("rxd_55", 2'd1, 8'h55);
        wb_wr(2'd2, 8'h0C);
        wb_wr(2'd1, 8'hC3);
        master_read(7'h22, 1);
        master_write(7'h23, 1, 8'h99);
        wb_wr(2'd3, 8'h02);
        master_write(7'h22, 2, 8'h11);
        rd_chk("rxd_second", 2'd1, m_rxd);
        repeat (3) @(posedge clk); #1;
        chk("irq_cleared", irq, 0);
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 4))
                0: master_write(7'h22, int'($urandom_range(1, 3)), 8'($urandom));
                1: master_write(7'($urandom_range(0, 127)) | 7'h01, 1, 8'($urandom));
                2: begin
                    if ($urandom_range(0, 1) == 1) wb_wr(2'd1, 8'($urandom));
                    master_read(7'h22, int'($urandom_range(1, 3)));
                end
                3: begin
                    wb_wr(2'd3, 8'($urandom) & 8'hFE);
                    wb_wr(2'd2, 8'($urandom));
                    check_stat("ien_stat");
                end
                default: begin
                    rd_chk("rand_rxd", 2'd1, m_rxd);
                    check_stat("rd_clr_stat");
                end
            endcase
        end
        // reset in the middle of a read while the slave is driving a 0
        wb_wr(2'd1, 8'h00);
        i2c_start();
        put_byte({7'h22, 1'b1}, acked);
        chk("mid_addr_ack", acked, 1);
        get_bit(b);
        get_bit(b);
        repeat (8) @(posedge clk); #1;
        chk("mid_sda_driven", sda_o, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sda", sda_o, 1);
        chk("mid_rst_scl", scl_o, 1);
        m_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        i2c_stop();
        check_stat("mid_rst_stat");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_slave_wb.md
# i2c_slave_wb

Synthesizable I2C slave endpoint with a Wishbone slave register port. It answers a configurable 7-bit address on one open-drain I2C bus and hands received bytes to the host over Wishbone. It also shifts host-supplied bytes out on I2C reads. It sits beside the I2C multi-bus master on the shared SCL/SDA wires, with the same Wishbone signal set as the master's host port.

## Interface
- WB_ADDR_WIDTH, 2, Wishbone register address width
- WB_DATA_WIDTH, 8, Wishbone data width
- I2C_ADDR_WIDTH, 7, I2C slave address width
- I2C_DATA_WIDTH, 8, I2C byte width
- clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- cyc_i  in  1  valid Wishbone cycle
- stb_i  in  1  slave select
- ack_o  out  1  Wishbone acknowledge
- adr_i  in  WB_ADDR_WIDTH  register address
- we_i  in  1  write enable
- dat_i  in  WB_DATA_WIDTH  write data
- dat_o  out  WB_DATA_WIDTH  read data
- irq_o  out  1  level interrupt
- scl_i / sda_i  in  1  I2C line inputs
- scl_o / sda_o  out  1  open-drain drives: 0 pulls the line low, 1 releases it

## Operation
- Registers:
  - 0 SADR: [7] enable, [6:0] own address; read/write.
  - 1 DATA: write loads TXD and clears tx_empty; read returns RXD and clears rx_valid and overrun.
  - 2 STAT: [7] rx_valid, [6] tx_empty, [5] busy, [4] dir (1 = master read), [3] master_nack, [2] stop_seen, [1] overrun, [0] 0; writing 1 clears bits 3 and 2, other bits are read-only.
  - 3 IEN: interrupt mask, same bit positions as STAT.
- irq_o = |(STAT & IEN), registered.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Repeated START is accepted in any state.
- Data bits are sampled on SCL rising, MSB first, 8 bits per byte plus one ACK bit.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
  - START from any state goes to ADDR; STOP from any state goes to IDLE and sets stop_seen if busy was 1.
  - ADDR: after 8 bits, if enable=1 and addr[7:1]==SADR[6:0], latch dir=bit0, set busy, go to ADDR_ACK; otherwise go to WAIT_STOP with SDA released.
  - ADDR_ACK: pull SDA low for the 9th clock. Then go to WR_DATA, or for a read load TXD into the shifter, set tx_empty, and go to RD_DATA.
  - A read with tx_empty already set sends 0xFF.
  - WR_DATA: after 8 bits copy to RXD; set overrun if rx_valid was already 1; set rx_valid; go to WR_ACK and ACK the byte.
  - RD_DATA: drive shifter MSB first, SDA updated after each SCL fall. RD_ACK samples the master's bit: ACK reloads TXD and returns to RD_DATA; NACK sets master_nack and goes to WAIT_STOP.
- scl_o is held at 1: no clock stretching.
- Reset state:
  - Outputs: ack_o=0, dat_o=0, irq_o=0, scl_o=1, sda_o=1.
  - Registers: SADR=0x00, IEN=0x00, STAT=0x40, RXD=TXD=0.
  - FSM in IDLE.

## Timing
- Wishbone ack_o asserts on the clock after cyc_i&stb_i with ack_o low and stays high one cycle. Read data is valid with ack. Register side effects commit on the ack cycle.
- scl_i/sda_i pass a 2-FF synchronizer, then edge detection, so 3 clk_i cycles of latency.
- sda_o changes are registered, at most 4 clk_i cycles after the detected SCL fall. clk_i must be at least 16x the SCL rate.
- ACK drive: SDA goes low after the 8th SCL fall and is released after the 9th SCL fall.
- When a Wishbone DATA read and an RXD update occur in the same cycle, rx_valid ends at 1 and overrun at 0.
- Reset asserted mid-transfer releases SDA and SCL immediately and returns the FSM to IDLE.

## Structure
- i2c_slave_wb_pkg holds register address constants, STAT bit indices and the FSM state enum.
- Sub-module i2c_line_sync: synchronizers plus SCL rise/fall, START and STOP pulses.

## Test plan
- Register access: write SADR=0xA2, read SADR -> 0xA2, 1-cycle ack; STAT after reset reads 0x40.
- Write transfer: SADR=0x80|0x22; master writes 0x55 to address 0x22 -> address and data ACKed, RXD=0x55, rx_valid=1; STOP sets stop_seen.
- Read transfer: TXD=0xC3; master reads 1 byte from 0x22 with NACK -> master receives 0xC3; master_nack=1 and tx_empty=1.
- Address mismatch: master addresses 0x23 -> NACK, sda_o stays 1; STAT busy=0.
- Overrun/irq: IEN=0x02; two written bytes without a DATA read -> overrun=1, irq_o=1, RXD=second byte; a DATA read clears overrun and irq_o.
- Reset mid-read: assert rst_i during RD_DATA -> sda_o=1 immediately and STAT=0x40.
